// File: rtl/fir_front_loader_pkg.sv
// Shared constants and load-state encoding for the FIR front loader.
// Imported by the sample FIFO and the loader top.
package fir_front_loader_pkg;

    localparam int CLK_DIV    = 20;
    localparam int NUM_BANK   = 4;
    localparam int NUM_TAP    = 10;
    localparam int COEFF_W    = 16;
    localparam int SAMPLE_W   = 3;
    localparam int FIFO_DEPTH = 4;

    localparam int CNT_W    = 5;
    localparam int BANK_W   = 2;
    localparam int TAP_W    = 4;
    localparam int ADDR_W   = BANK_W + TAP_W;
    localparam int FIFO_AW  = 2;
    localparam int FIFO_CW  = FIFO_AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        RUN  = 2'd3
    } loadState_t;

    // RAM address is the bank in the upper bits, tap index in the lower nibble.
    function automatic logic [ADDR_W-1:0] ramAddr(input logic [BANK_W-1:0] bank,
                                                  input logic [TAP_W-1:0]  tap);
        return {bank, tap};
    endfunction

endpackage

// File: rtl/fir_front_loader_sample_fifo.sv
// Small synchronous sample FIFO; a pop on a full FIFO frees room for a
// same-cycle push. Overflow/underflow are sticky until reset.
module fir_sample_fifo
    import fir_front_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [SAMPLE_W-1:0] pushData,
    input  logic                pop,
    output logic [SAMPLE_W-1:0] rdData,
    output logic                full,
    output logic                empty,
    output logic                overflow,
    output logic                underflow
);

    logic [SAMPLE_W-1:0] mem_r [FIFO_DEPTH];
    logic [FIFO_AW-1:0]  wrPtr_r;
    logic [FIFO_AW-1:0]  rdPtr_r;
    logic [FIFO_CW-1:0]  count_r;
    logic                overflow_r;
    logic                underflow_r;
    logic                doPush_s;
    logic                doPop_s;

    // Accept/serve decisions for this cycle.
    always_comb begin
        full     = (count_r == FIFO_CW'(FIFO_DEPTH));
        empty    = (count_r == {FIFO_CW{1'b0}});
        doPop_s  = pop & ~empty;
        doPush_s = push & (~full | pop);
        rdData   = mem_r[rdPtr_r];
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (doPush_s) begin
            mem_r[wrPtr_r] <= pushData;
        end
    end

    // Pointers, occupancy and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_r     <= {FIFO_AW{1'b0}};
            rdPtr_r     <= {FIFO_AW{1'b0}};
            count_r     <= {FIFO_CW{1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (doPush_s) begin
                wrPtr_r <= wrPtr_r + FIFO_AW'(1);
            end
            if (doPop_s) begin
                rdPtr_r <= rdPtr_r + FIFO_AW'(1);
            end
            count_r <= count_r + FIFO_CW'(doPush_s) - FIFO_CW'(doPop_s);
            if (push & full & ~pop) begin
                overflow_r <= 1'b1;
            end
            if (pop & empty) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_r;
    assign underflow = underflow_r;

endmodule

// File: rtl/fir_front_loader.sv
// Upstream feeder for the FIR filter: 600 kHz strobe, sample buffering and
// the coefficient RAM programming sequence. Every output is a flop.
module fir_front_loader
    import fir_front_loader_pkg::*;
(
    input  logic                iClk12M,
    input  logic                iRsn,
    input  logic                iLoadStart,
    input  logic                iCoeffValid,
    input  logic [COEFF_W-1:0]  iCoeffData,
    output logic                oCoeffReady,
    input  logic                iSampleValid,
    input  logic [SAMPLE_W-1:0] iSampleIn,
    output logic                oEnSample600k,
    output logic [SAMPLE_W-1:0] oFirIn,
    output logic                oCoeffUpdateFlag,
    output logic                oMemRdFlag,
    output logic                oCsnRam,
    output logic                oWrnRam,
    output logic                oEnMAC,
    output logic [ADDR_W-1:0]   oAddrRam,
    output logic [COEFF_W-1:0]  oWtDtRam,
    output logic                oLoadDone,
    output logic                oOverflow,
    output logic                oUnderflow
);

    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cntNxt_s;
    logic                strobe_r;
    logic                pop_s;
    logic [SAMPLE_W-1:0] firIn_r;
    logic [SAMPLE_W-1:0] fifoHead_s;
    logic                fifoFull_s;
    logic                fifoEmpty_s;

    loadState_t          state_r, stateNxt_s;
    logic [BANK_W-1:0]   bank_r, bankNxt_s;
    logic [TAP_W-1:0]    tap_r, tapNxt_s;
    logic                ready_r, readyNxt_s;
    logic                upd_r, updNxt_s;
    logic                memRd_r, memRdNxt_s;
    logic                enMac_r, enMacNxt_s;
    logic                csn_r, csnNxt_s;
    logic                wrn_r, wrnNxt_s;
    logic [ADDR_W-1:0]   addr_r, addrNxt_s;
    logic [COEFF_W-1:0]  data_r, dataNxt_s;
    logic                loadDone_r, loadDoneNxt_s;
    logic                beat_s;

    // Strobe counter wrap and pop timing (pop lands on the edge into the strobe).
    always_comb begin
        if (cnt_r == CNT_W'(CLK_DIV - 1)) begin
            cntNxt_s = {CNT_W{1'b0}};
        end else begin
            cntNxt_s = cnt_r + CNT_W'(1);
        end
        pop_s = (cnt_r == CNT_W'(CLK_DIV - 2));
    end

    // Strobe counter, registered strobe and filter input sample.
    always_ff @(posedge iClk12M) begin
        if (iRsn) begin
            cnt_r    <= {CNT_W{1'b0}};
            strobe_r <= 1'b0;
            firIn_r  <= {SAMPLE_W{1'b0}};
        end else begin
            cnt_r    <= cntNxt_s;
            strobe_r <= (cntNxt_s == CNT_W'(CLK_DIV - 1));
            if (pop_s) begin
                firIn_r <= fifoEmpty_s ? {SAMPLE_W{1'b0}} : fifoHead_s;
            end
        end
    end

    fir_sample_fifo uFifo (
        .clk       (iClk12M),
        .rst       (iRsn),
        .push      (iSampleValid),
        .pushData  (iSampleIn),
        .pop       (pop_s),
        .rdData    (fifoHead_s),
        .full      (fifoFull_s),
        .empty     (fifoEmpty_s),
        .overflow  (oOverflow),
        .underflow (oUnderflow)
    );

    assign beat_s = iCoeffValid & ready_r;

    // Load FSM: next state plus the next value of every registered RAM/handshake output.
    always_comb begin
        stateNxt_s    = state_r;
        bankNxt_s     = bank_r;
        tapNxt_s      = tap_r;
        readyNxt_s    = 1'b0;
        updNxt_s      = 1'b0;
        memRdNxt_s    = 1'b0;
        enMacNxt_s    = 1'b0;
        csnNxt_s      = 1'b1;
        wrnNxt_s      = 1'b1;
        addrNxt_s     = addr_r;
        dataNxt_s     = data_r;
        loadDoneNxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                addrNxt_s = {ADDR_W{1'b0}};
                dataNxt_s = {COEFF_W{1'b0}};
                if (iLoadStart) begin
                    stateNxt_s = LOAD;
                    bankNxt_s  = {BANK_W{1'b0}};
                    tapNxt_s   = {TAP_W{1'b0}};
                    readyNxt_s = 1'b1;
                    updNxt_s   = 1'b1;
                end else begin
                    stateNxt_s = IDLE;
                end
            end
            LOAD: begin
                updNxt_s   = 1'b1;
                readyNxt_s = 1'b1;
                if (beat_s) begin
                    csnNxt_s  = 1'b0;
                    wrnNxt_s  = 1'b0;
                    addrNxt_s = ramAddr(bank_r, tap_r);
                    dataNxt_s = iCoeffData;
                    if (tap_r == TAP_W'(NUM_TAP - 1)) begin
                        tapNxt_s = {TAP_W{1'b0}};
                        if (bank_r == BANK_W'(NUM_BANK - 1)) begin
                            stateNxt_s    = DONE;
                            readyNxt_s    = 1'b0;
                            loadDoneNxt_s = 1'b1;
                        end else begin
                            bankNxt_s = bank_r + BANK_W'(1);
                        end
                    end else begin
                        tapNxt_s = tap_r + TAP_W'(1);
                    end
                end else begin
                    csnNxt_s = 1'b1;
                end
            end
            DONE: begin
                stateNxt_s = RUN;
                memRdNxt_s = 1'b1;
                enMacNxt_s = 1'b1;
                csnNxt_s   = 1'b0;
                addrNxt_s  = {ADDR_W{1'b0}};
            end
            RUN: begin
                if (iLoadStart) begin
                    stateNxt_s = LOAD;
                    bankNxt_s  = {BANK_W{1'b0}};
                    tapNxt_s   = {TAP_W{1'b0}};
                    readyNxt_s = 1'b1;
                    updNxt_s   = 1'b1;
                end else begin
                    memRdNxt_s = 1'b1;
                    enMacNxt_s = 1'b1;
                    csnNxt_s   = 1'b0;
                    addrNxt_s  = {ADDR_W{1'b0}};
                end
            end
            default: begin
                stateNxt_s = IDLE;
            end
        endcase
    end

    // Load FSM state and registered outputs.
    always_ff @(posedge iClk12M) begin
        if (iRsn) begin
            state_r    <= IDLE;
            bank_r     <= {BANK_W{1'b0}};
            tap_r      <= {TAP_W{1'b0}};
            ready_r    <= 1'b0;
            upd_r      <= 1'b0;
            memRd_r    <= 1'b0;
            enMac_r    <= 1'b0;
            csn_r      <= 1'b1;
            wrn_r      <= 1'b1;
            addr_r     <= {ADDR_W{1'b0}};
            data_r     <= {COEFF_W{1'b0}};
            loadDone_r <= 1'b0;
        end else begin
            state_r    <= stateNxt_s;
            bank_r     <= bankNxt_s;
            tap_r      <= tapNxt_s;
            ready_r    <= readyNxt_s;
            upd_r      <= updNxt_s;
            memRd_r    <= memRdNxt_s;
            enMac_r    <= enMacNxt_s;
            csn_r      <= csnNxt_s;
            wrn_r      <= wrnNxt_s;
            addr_r     <= addrNxt_s;
            data_r     <= dataNxt_s;
            loadDone_r <= loadDoneNxt_s;
        end
    end

    assign oEnSample600k    = strobe_r;
    assign oFirIn           = firIn_r;
    assign oCoeffReady      = ready_r;
    assign oCoeffUpdateFlag = upd_r;
    assign oMemRdFlag       = memRd_r;
    assign oEnMAC           = enMac_r;
    assign oCsnRam          = csn_r;
    assign oWrnRam          = wrn_r;
    assign oAddrRam         = addr_r;
    assign oWtDtRam         = data_r;
    assign oLoadDone        = loadDone_r;

endmodule

// File: doc/fir_front_loader.md
Name: fir_front_loader

Overview:
- Upstream feeder for the reconfigurable FIR filter top.
- Generates the 600 kHz sample strobe from the 12 MHz clock.
- Buffers incoming 3-bit samples in a small FIFO and presents one per strobe.
- Runs the coefficient-programming sequence: accepts 40 coefficients over a valid/ready stream, writes them into the filter's four 10x16 coefficient RAMs, then switches the filter to read/MAC mode.

Parameters:
- CLK_DIV, 20, clock cycles per sample strobe (12 MHz / 600 kHz).
- NUM_BANK, 4, coefficient RAM banks (MAC lanes).
- NUM_TAP, 10, taps per bank.
- COEFF_W, 16, coefficient width.
- SAMPLE_W, 3, input sample width.
- FIFO_DEPTH, 4, sample FIFO entries (power of two).

Ports:
- iClk12M  in  1  12 MHz clock; all logic on rising edge.
- iRsn  in  1  reset, synchronous, active-high.
- iLoadStart  in  1  one-cycle pulse; starts a coefficient load.
- iCoeffValid  in  1  coefficient beat valid.
- iCoeffData  in  COEFF_W  coefficient value.
- oCoeffReady  out  1  loader accepts a beat.
- iSampleValid  in  1  push iSampleIn into the FIFO.
- iSampleIn  in  SAMPLE_W  raw sample.
- oEnSample600k  out  1  sample strobe.
- oFirIn  out  SAMPLE_W  sample to the filter.
- oCoeffUpdateFlag  out  1  coefficient load in progress.
- oMemRdFlag  out  1  coefficients valid, filter in read mode.
- oCsnRam  out  1  RAM chip select, active-low.
- oWrnRam  out  1  RAM write enable, active-low.
- oEnMAC  out  1  MAC enable.
- oAddrRam  out  6  {bank[1:0], tap[3:0]}.
- oWtDtRam  out  COEFF_W  RAM write data.
- oLoadDone  out  1  one-cycle pulse on load completion.
- oOverflow  out  1  sticky; a sample was dropped.
- oUnderflow  out  1  sticky; a strobe found the FIFO empty.

Behaviour:
- Reset values: oCsnRam = 1 and oWrnRam = 1. All other outputs = 0. State = IDLE. Strobe counter = 0. FIFO empty.
- All outputs are registered.
- Strobe generation:
  - Counter runs 0..CLK_DIV-1 and wraps. It runs in every state.
  - oEnSample600k is high for exactly one cycle, while the counter = CLK_DIV-1.
  - The first pulse occurs in the 20th cycle after reset deasserts.
- Sample FIFO:
  - Pop happens on the edge where the counter goes CLK_DIV-2 -> CLK_DIV-1. The popped value is loaded into oFirIn, so oFirIn is stable through the strobe.
  - Empty at pop: oFirIn = 0 and oUnderflow is set.
  - Full at push: the sample is dropped and oOverflow is set, unless a pop occurs in the same cycle; then push and pop both succeed.
  - Sticky flags clear only on reset.
- Load FSM has states IDLE, LOAD, DONE, RUN.
- IDLE:
  - Outputs are at their reset values.
  - iLoadStart -> LOAD; bank = 0, tap = 0.
- LOAD:
  - oCoeffUpdateFlag = 1, oCoeffReady = 1, oEnMAC = 0, oMemRdFlag = 0.
  - Each beat with iCoeffValid & oCoeffReady produces, on the next cycle only: oCsnRam = 0, oWrnRam = 0, oAddrRam = {bank, tap}, oWtDtRam = iCoeffData.
  - Cycles without a beat: oCsnRam = 1, oWrnRam = 1, and address/data hold their last values.
  - Tap increments per beat; tap = NUM_TAP-1 wraps to 0 and increments bank.
  - Beat at bank = NUM_BANK-1, tap = NUM_TAP-1 -> DONE; oCoeffReady drops the same edge.
  - iLoadStart in LOAD is ignored.
- DONE (one cycle):
  - The last write is visible.
  - oCoeffUpdateFlag stays 1.
  - oLoadDone = 1.
  - Transition to RUN.
- RUN:
  - oCoeffUpdateFlag = 0, oMemRdFlag = 1, oEnMAC = 1, oCsnRam = 0, oWrnRam = 1, oAddrRam = 0.
  - iLoadStart -> LOAD. oMemRdFlag and oEnMAC drop on the same edge; bank and tap are cleared.
- Reset mid-operation: all of the above returns to reset values on the next edge. Partially loaded RAM content is not tracked.

Decomposition:
- Shared package: CLK_DIV, NUM_BANK, NUM_TAP, COEFF_W, SAMPLE_W, and the load-state enum.
- Sub-module fir_sample_fifo: synchronous FIFO with push, pop, full, empty, data and sticky overflow/underflow.
- Strobe counter and load FSM stay in the top.

Test Plan:
- Reset:
  - Stimulus: hold iRsn = 1 for 3 cycles, then release.
  - Required: all outputs at reset values; first oEnSample600k in the 20th cycle after release, then every 20 cycles.
- Sample path:
  - Stimulus: push 3, 5, 7; observe 4 strobes.
  - Required: oFirIn = 3, 5, 7, 0 at successive strobes; oUnderflow = 1 after the 4th.
- Overflow:
  - Stimulus: push 6 samples back-to-back with no strobe between.
  - Required: FIFO holds the first 4; oOverflow = 1.
- Full load with bubbles:
  - Stimulus: iLoadStart, then 40 beats with data 0x1000 + i and iCoeffValid low every third cycle.
  - Required: write cycles at addresses 0x00..0x09, 0x10..0x19, 0x20..0x29, 0x30..0x39 with matching data; oLoadDone pulses once; RUN with oEnMAC = 1.
- Reload from RUN:
  - Stimulus: iLoadStart while in RUN.
  - Required: oEnMAC and oMemRdFlag = 0 on the next cycle; the next beat writes address 0x00.
- Reset mid-load:
  - Stimulus: assert iRsn after 15 beats.
  - Required: IDLE; oCoeffReady = 0; oCsnRam = 1; a new iLoadStart restarts at address 0x00.
